// File: rtl/vga_pkg.sv
// Shared VGA constants, scale encoding, motion FSM states and the per-axis
// bounce helper.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 800;
  localparam int unsigned V_ACTIVE_DEF = 600;

  localparam int unsigned R_W = 5;
  localparam int unsigned G_W = 6;
  localparam int unsigned B_W = 5;
  localparam int unsigned RGB_W = R_W + G_W + B_W;

  localparam logic [1:0] SCALE_1X = 2'd0;
  localparam logic [1:0] SCALE_2X = 2'd1;
  localparam logic [1:0] SCALE_4X = 2'd2;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } motion_state_e;

  typedef struct packed {
    logic [11:0] pos;
    logic        flip;
  } axis_t;

  // Shift amount for the scale code; code 3 behaves as 4x.
  function automatic logic [1:0] scale_shift(input logic [1:0] sc);
    logic [1:0] r;
    case (sc)
      SCALE_1X: r = 2'd0;
      SCALE_2X: r = 2'd1;
      default:  r = 2'd2;
    endcase
    return r;
  endfunction

  // Candidate position for one axis; clamps to the edge and flags a bounce.
  function automatic axis_t axis_next(input logic [11:0] pos, input logic dir,
                                      input logic [3:0] step, input logic [13:0] size,
                                      input logic [13:0] limit);
    axis_t       r;
    logic [13:0] p;
    logic [13:0] s;
    p      = {2'b00, pos};
    s      = {10'd0, step};
    r.flip = 1'b0;
    if (dir) begin
      if (p + s + size > limit) begin
        r.pos  = 12'(limit - size);
        r.flip = 1'b1;
      end else begin
        r.pos = 12'(p + s);
      end
    end else if (p < s) begin
      r.pos  = '0;
      r.flip = 1'b1;
    end else begin
      r.pos = 12'(p - s);
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Width/depth-parametrised shift register with asynchronous active-low clear.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_bitmap_sprite.sv
// 1-bpp ROM bitmap rendered as a scalable, optionally bouncing sprite with
// registered RGB565 output; latency col/row -> RGB is 2+ROM_LAT cycles.
module vga_bitmap_sprite
  import vga_pkg::*;
#(
  parameter int unsigned IMG_W    = 80,
  parameter int unsigned IMG_H    = 86,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              ready_sig,
  input  logic [11:0]       col_addr,
  input  logic [11:0]       row_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IMG_W-1:0]  rom_data,
  input  logic              move_en,
  input  logic [3:0]        step,
  input  logic [1:0]        scale,
  input  logic [15:0]       fg_rgb,
  input  logic [15:0]       bg_rgb,
  output logic [R_W-1:0]    red_sig,
  output logic [G_W-1:0]    green_sig,
  output logic [B_W-1:0]    blue_sig,
  output logic [11:0]       pos_x,
  output logic [11:0]       pos_y,
  output logic              hit_edge
);

  localparam int unsigned DX_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned CW   = 14;

  logic [1:0]       scale_q;
  logic [3:0]       step_q;
  logic [15:0]      fg_q, bg_q;
  logic             frame_end;
  logic [1:0]       shift;
  logic [CW-1:0]    sw, sh, col_off, row_off;
  logic             in_x, in_y;

  logic [ADDR_W-1:0] rom_addr_q;
  logic              s1_ready_q, s1_in_q;
  logic [DX_W-1:0]   s1_dx_q;
  logic              al_ready, al_in;
  logic [DX_W-1:0]   al_dx;
  logic [RGB_W-1:0]  rgb_q;

  motion_state_e state_q, state_d;
  logic [11:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [11:0]   cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic          flip_x_q, flip_x_d, flip_y_q, flip_y_d;
  axis_t         ax, ay;

  assign frame_end = ready_sig && (col_addr == 12'(H_ACTIVE - 1)) &&
                     (row_addr == 12'(V_ACTIVE - 1));

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_q <= SCALE_1X;
      step_q  <= '0;
      fg_q    <= '1;
      bg_q    <= '0;
    end else if (frame_end) begin
      scale_q <= scale;
      step_q  <= step;
      fg_q    <= fg_rgb;
      bg_q    <= bg_rgb;
    end
  end

  assign shift   = scale_shift(scale_q);
  assign sw      = CW'(IMG_W) << shift;
  assign sh      = CW'(IMG_H) << shift;
  assign col_off = CW'(col_addr) - CW'(pos_x_q);
  assign row_off = CW'(row_addr) - CW'(pos_y_q);
  assign in_x    = (col_addr >= pos_x_q) && (col_off < sw);
  assign in_y    = (row_addr >= pos_y_q) && (row_off < sh);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      s1_ready_q <= 1'b0;
      s1_in_q    <= 1'b0;
      s1_dx_q    <= '0;
      rgb_q      <= '0;
    end else begin
      rom_addr_q <= ADDR_W'(row_off >> shift);
      s1_ready_q <= ready_sig;
      s1_in_q    <= in_x && in_y;
      s1_dx_q    <= DX_W'(col_off >> shift);
      rgb_q      <= (al_ready && al_in) ? (rom_data[al_dx] ? fg_q : bg_q) : '0;
    end
  end

  // Qualifiers and bit index ride alongside the ROM read so they meet rom_data.
  vga_delay_line #(
    .WIDTH(DX_W + 2),
    .DEPTH(ROM_LAT)
  ) u_align (
    .clk_i (vga_clk),
    .rst_ni(rst_n),
    .d_i   ({s1_ready_q, s1_in_q, s1_dx_q}),
    .q_o   ({al_ready, al_in, al_dx})
  );

  assign rom_addr  = rom_addr_q;
  assign red_sig   = rgb_q[RGB_W-1 -: R_W];
  assign green_sig = rgb_q[B_W +: G_W];
  assign blue_sig  = rgb_q[B_W-1:0];

  assign ax = axis_next(pos_x_q, dir_x_q, step_q, sw, CW'(H_ACTIVE));
  assign ay = axis_next(pos_y_q, dir_y_q, step_q, sh, CW'(V_ACTIVE));

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SCAN;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      flip_x_q <= 1'b0;
      flip_y_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      flip_x_q <= flip_x_d;
      flip_y_q <= flip_y_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    flip_x_d = flip_x_q;
    flip_y_d = flip_y_q;
    hit_edge = 1'b0;
    case (state_q)
      SCAN: if (frame_end && move_en) state_d = CALC;
      CALC: begin
        cand_x_d = ax.pos;
        cand_y_d = ay.pos;
        flip_x_d = ax.flip;
        flip_y_d = ay.flip;
        state_d  = COMMIT;
      end
      COMMIT: begin
        pos_x_d  = cand_x_q;
        pos_y_d  = cand_y_q;
        dir_x_d  = dir_x_q ^ flip_x_q;
        dir_y_d  = dir_y_q ^ flip_y_q;
        hit_edge = flip_x_q | flip_y_q;
        state_d  = SCAN;
      end
      default: state_d = SCAN;
    endcase
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;

endmodule

// File: tb/tb_vga_bitmap_sprite.sv
// Bench for vga_bitmap_sprite: ROM_LAT=1 and ROM_LAT=3 instances share stimulus,
// pixels go through cycle-tagged scoreboards, motion against a behavioural model.
module tb_vga_bitmap_sprite;

  localparam int IMG_W = 80;
  localparam int IMG_H = 86;
  localparam int HA    = 800;
  localparam int VA    = 600;
  localparam int LAT_A = 3;
  localparam int LAT_B = 5;

  logic        vga_clk, rst_n, ready_sig, move_en;
  logic [11:0] col_addr, row_addr;
  logic [3:0]  step;
  logic [1:0]  scale;
  logic [15:0] fg_rgb, bg_rgb;

  logic [6:0]  rom_addr_a, rom_addr_b;
  logic [79:0] rom_data_a, rom_data_b;
  logic [4:0]  red_a, red_b, blue_a, blue_b;
  logic [5:0]  green_a, green_b;
  logic [11:0] pos_x_a, pos_x_b, pos_y_a, pos_y_b;
  logic        hit_a, hit_b;

  vga_bitmap_sprite #(.ROM_LAT(1)) dut_a (
    .vga_clk(vga_clk), .rst_n(rst_n), .ready_sig(ready_sig),
    .col_addr(col_addr), .row_addr(row_addr), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .move_en(move_en), .step(step), .scale(scale), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
    .red_sig(red_a), .green_sig(green_a), .blue_sig(blue_a),
    .pos_x(pos_x_a), .pos_y(pos_y_a), .hit_edge(hit_a));

  vga_bitmap_sprite #(.ROM_LAT(3)) dut_b (
    .vga_clk(vga_clk), .rst_n(rst_n), .ready_sig(ready_sig),
    .col_addr(col_addr), .row_addr(row_addr), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .move_en(move_en), .step(step), .scale(scale), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
    .red_sig(red_b), .green_sig(green_b), .blue_sig(blue_b),
    .pos_x(pos_x_b), .pos_y(pos_y_b), .hit_edge(hit_b));

  logic [79:0] rom [IMG_H];
  logic [79:0] pipe_b [3];

  function automatic logic [79:0] rom_rd(input logic [6:0] a);
    return (int'(a) < IMG_H) ? rom[a] : 80'd0;
  endfunction

  always @(posedge vga_clk) begin
    rom_data_a <= rom_rd(rom_addr_a);
    pipe_b[0]  <= rom_rd(rom_addr_b);
    pipe_b[1]  <= pipe_b[0];
    pipe_b[2]  <= pipe_b[1];
  end
  assign rom_data_b = pipe_b[2];

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [15:0] exp;
    bit          chk;
  } sb_t;
  sb_t qa[$], qb[$];
  sb_t ea, eb;

  always @(negedge vga_clk) begin
    if (rst_n) begin
      while (qa.size() > 0 && qa[0].cyc + LAT_A <= cyc) begin
        ea = qa.pop_front();
        if (ea.chk && ea.cyc + LAT_A == cyc) check("rgb_lat1", {red_a, green_a, blue_a}, ea.exp);
      end
      while (qb.size() > 0 && qb[0].cyc + LAT_B <= cyc) begin
        eb = qb.pop_front();
        if (eb.chk && eb.cyc + LAT_B == cyc) check("rgb_lat3", {red_b, green_b, blue_b}, eb.exp);
      end
    end
  end

  // Behavioural model of shadow registers and motion.
  int          m_px, m_py, m_shift, m_step;
  bit          m_dx, m_dy, m_hit;
  logic [15:0] m_fg, m_bg;

  task automatic model_reset();
    m_px = 0; m_py = 0; m_dx = 1; m_dy = 1;
    m_shift = 0; m_step = 0; m_fg = 16'hFFFF; m_bg = 16'h0000;
  endtask

  function automatic logic [15:0] model_px(input int c, input int r, input bit rdy);
    int          swd, shd, dx, dy;
    logic [79:0] w;
    swd = IMG_W << m_shift;
    shd = IMG_H << m_shift;
    if (!rdy || c < m_px || c >= m_px + swd || r < m_py || r >= m_py + shd) return 16'h0000;
    dx = (c - m_px) >> m_shift;
    dy = (r - m_py) >> m_shift;
    w  = rom[dy];
    return w[dx] ? m_fg : m_bg;
  endfunction

  task automatic model_axis(inout int p, inout bit d, input int sz, input int lim, output bit f);
    f = 0;
    if (d) begin
      if (p + m_step + sz > lim) begin p = lim - sz; f = 1; end
      else p = p + m_step;
    end else begin
      if (p < m_step) begin p = 0; f = 1; end
      else p = p - m_step;
    end
    if (f) d = !d;
  endtask

  task automatic model_frame_end();
    bit fx, fy;
    m_shift = (scale == 2'd0) ? 0 : (scale == 2'd1) ? 1 : 2;
    m_step  = int'(step);
    m_fg    = fg_rgb;
    m_bg    = bg_rgb;
    m_hit   = 0;
    if (move_en) begin
      model_axis(m_px, m_dx, IMG_W << m_shift, HA, fx);
      model_axis(m_py, m_dy, IMG_H << m_shift, VA, fy);
      m_hit = fx | fy;
    end
  endtask

  task automatic drive(input int c, input int r, input bit rdy, input bit chk, input logic [15:0] exp);
    sb_t e;
    @(posedge vga_clk);
    #1;
    col_addr  = 12'(c);
    row_addr  = 12'(r);
    ready_sig = rdy;
    e.cyc = cyc; e.exp = exp; e.chk = chk;
    qa.push_back(e);
    qb.push_back(e);
  endtask

  task automatic drive_m(input int c, input int r, input bit rdy);
    drive(c, r, rdy, 1'b1, model_px(c, r, rdy));
  endtask

  task automatic frame_end();
    repeat (6) drive(0, 0, 1'b0, 1'b1, 16'h0000);
    drive(HA - 1, VA - 1, 1'b1, 1'b0, 16'h0000);
    model_frame_end();
    drive(0, 0, 1'b0, 1'b1, 16'h0000);
    check("hit_early_a", 32'(hit_a), 0);
    check("hit_early_b", 32'(hit_b), 0);
    drive(0, 0, 1'b0, 1'b1, 16'h0000);
    check("hit_a", 32'(hit_a), 32'(m_hit));
    check("hit_b", 32'(hit_b), 32'(m_hit));
    drive(0, 0, 1'b0, 1'b1, 16'h0000);
    check("hit_late_a", 32'(hit_a), 0);
    check("hit_late_b", 32'(hit_b), 0);
    check("pos_x_a", 32'(pos_x_a), 32'(m_px));
    check("pos_y_a", 32'(pos_y_a), 32'(m_py));
    check("pos_x_b", 32'(pos_x_b), 32'(m_px));
    check("pos_y_b", 32'(pos_y_b), 32'(m_py));
  endtask

  task automatic probe_sprite();
    int swd;
    swd = IMG_W << m_shift;
    drive_m(m_px, m_py, 1'b1);
    if (m_px > 0) drive_m(m_px - 1, m_py, 1'b1);
    drive_m(m_px + swd - 1, m_py, 1'b1);
    drive_m(m_px + swd, m_py, 1'b1);
  endtask

  task automatic check_reset_outputs();
    check("rst_rgb_a", 32'({red_a, green_a, blue_a}), 0);
    check("rst_rgb_b", 32'({red_b, green_b, blue_b}), 0);
    check("rst_pos_a", 32'({pos_x_a, pos_y_a}), 0);
    check("rst_pos_b", 32'({pos_x_b, pos_y_b}), 0);
    check("rst_hit", 32'({hit_a, hit_b}), 0);
    check("rst_rom_addr", 32'({rom_addr_a, rom_addr_b}), 0);
  endtask

  typedef struct {
    int          col;
    int          row;
    bit          rdy;
    logic [15:0] exp;
  } vec_t;
  vec_t t_static[6];
  vec_t t_scale[15];

  task automatic run_static();
    foreach (t_static[i]) drive(t_static[i].col, t_static[i].row, t_static[i].rdy, 1'b1, t_static[i].exp);
    repeat (6) drive(0, 0, 1'b0, 1'b1, 16'h0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    foreach (rom[i]) rom[i] = 80'd0;
    rom[0]  = 80'h1;
    rom[5]  = 80'h8;
    rom[20] = 80'hA5A5_0F0F_3C3C_1234_5678;

    t_static = '{'{0, 0, 1'b1, 16'hFFFF}, '{1, 0, 1'b1, 16'h0000}, '{0, 1, 1'b1, 16'h0000},
                 '{79, 0, 1'b1, 16'h0000}, '{80, 0, 1'b1, 16'h0000}, '{0, 0, 1'b0, 16'h0000}};
    t_scale  = '{'{6, 10, 1'b1, 16'hF81F}, '{7, 11, 1'b1, 16'hF81F}, '{7, 10, 1'b1, 16'hF81F},
                 '{6, 11, 1'b1, 16'hF81F}, '{5, 10, 1'b1, 16'h07E0}, '{8, 10, 1'b1, 16'h07E0},
                 '{6, 9, 1'b1, 16'h07E0}, '{6, 12, 1'b1, 16'h07E0}, '{0, 0, 1'b1, 16'hF81F},
                 '{1, 1, 1'b1, 16'hF81F}, '{2, 0, 1'b1, 16'h07E0}, '{159, 171, 1'b1, 16'h07E0},
                 '{160, 0, 1'b1, 16'h0000}, '{0, 172, 1'b1, 16'h0000}, '{6, 10, 1'b0, 16'h0000}};

    rst_n = 1'b0; ready_sig = 1'b0; col_addr = '0; row_addr = '0;
    move_en = 1'b0; step = 4'd0; scale = 2'd0; fg_rgb = 16'h1234; bg_rgb = 16'h4321;
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Static sprite with shadow reset colours.
    run_static();

    // 2x scaling latched at frame end.
    scale = 2'd1; fg_rgb = 16'hF81F; bg_rgb = 16'h07E0;
    frame_end();
    foreach (t_scale[i]) drive(t_scale[i].col, t_scale[i].row, t_scale[i].rdy, 1'b1, t_scale[i].exp);

    // Mid-frame colour change must wait for the next frame.
    fg_rgb = 16'h001F; bg_rgb = 16'h7BEF;
    drive(6, 10, 1'b1, 1'b1, 16'hF81F);
    drive(6, 150, 1'b1, 1'b1, 16'h07E0);
    drive(0, 0, 1'b1, 1'b1, 16'hF81F);
    frame_end();
    drive(6, 10, 1'b1, 1'b1, 16'h001F);
    drive(6, 150, 1'b1, 1'b1, 16'h7BEF);

    // Motion: diagonal run, then a scale-up clamp on both axes at once.
    scale = 2'd0; fg_rgb = 16'hFFE0; bg_rgb = 16'h0010; move_en = 1'b1; step = 4'd7;
    for (int f = 0; f < 70; f++) begin
      frame_end();
      probe_sprite();
    end
    check("pos_490_x", 32'(pos_x_a), 490);
    scale = 2'd3; step = 4'd0;
    frame_end();
    check("corner_hit", 32'(m_hit), 1);
    check("corner_pos_x", 32'(pos_x_b), 480);
    check("corner_pos_y", 32'(pos_y_b), 256);
    probe_sprite();
    step = 4'd4;
    frame_end();
    check("after_corner_x", 32'(pos_x_a), 476);
    check("after_corner_y", 32'(pos_y_a), 252);
    step = 4'd0;
    frame_end();
    probe_sprite();
    scale = 2'd0; step = 4'd15;
    for (int f = 0; f < 40; f++) begin
      frame_end();
      probe_sprite();
    end
    move_en = 1'b0;
    frame_end();

    // Asynchronous reset in the middle of active video.
    repeat (6) drive_m(m_px, m_py, 1'b1);
    drive(400, 200, 1'b1, 1'b0, 16'h0000);
    check("pre_rst_rgb_a", 32'({red_a, green_a, blue_a}), 32'(m_fg));
    check("pre_rst_rgb_b", 32'({red_b, green_b, blue_b}), 32'(m_fg));
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    qa.delete();
    qb.delete();
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    rst_n = 1'b1;
    repeat (2) drive(0, 0, 1'b0, 1'b1, 16'h0000);
    run_static();

    repeat (8) drive(0, 0, 1'b0, 1'b1, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
